mtsp_sync_barrier: RTL and testbench
====================================

// Module: mtsp_sync_barrier
// PURPOSE
//  Responder side of the multi-core sync interface. Each core's thread scheduler pulses its sync enable
//  when a thread issues a sync; this block collects arrivals from all participating cores and returns a
//  one-cycle ack to every participant once the last one arrives. The scheduler then wakes the stalled threads.
//  It sits at the multi-core top level, one instance shared by all cores.
// PARAMETERS
//  CORE_COUNT     4      number of cores attached (1..16)
//  TIMEOUT_CYCLES 65535  gather cycles before TIMEOUT flag sets (0 = timeout disabled)
//  GEN_W          8      width of barrier generation counter
// PORTS
//  CLK        in   1           system clock
//  RST        in   1           synchronous reset, active high
//  CORE_MASK  in   CORE_COUNT  1 = core participates in barrier
//  SYNC_EN    in   CORE_COUNT  per-core sync request pulse (core_sync.en)
//  SYNC_ACK   out  CORE_COUNT  per-core release pulse (core_sync.ack), registered
//  ARRIVED    out  CORE_COUNT  cores latched in current barrier
//  BUSY       out  1           barrier gathering (at least one arrival pending)
//  GEN        out  GEN_W       count of completed barriers, wraps modulo 2^GEN_W
//  TIMEOUT    out  1           sticky: gather exceeded TIMEOUT_CYCLES
//  ERR_DUP    out  1           sticky: core re-requested while already arrived
//  CLR        in   1           clears TIMEOUT and ERR_DUP (single-cycle pulse)
// BEHAVIOUR
//  Reset (RST=1 at CLK edge): SYNC_ACK=0, ARRIVED=0, BUSY=0, GEN=0, TIMEOUT=0, ERR_DUP=0, FSM=IDLE, timer=0.
//  FSM states: IDLE, GATHER, RELEASE.
//   IDLE: any masked SYNC_EN -> set ARRIVED bits; if (ARRIVED_next & MASK)==MASK -> RELEASE, else GATHER.
//   GATHER: OR masked SYNC_EN into ARRIVED; when (ARRIVED_next & MASK)==MASK -> RELEASE. Timer +1 per cycle.
//   RELEASE: exactly one cycle; SYNC_ACK = MASK (only participants), ARRIVED cleared, GEN+1, timer=0 -> IDLE.
//  Latency: final arrival at cycle N -> SYNC_ACK high for cycle N+1 only, never held.
//  Arrival in RELEASE cycle: latched into ARRIVED for the next barrier (not lost); FSM -> GATHER,
//   or straight back to RELEASE if it alone completes the mask.
//  Unmasked core asserting SYNC_EN: bypass, its SYNC_ACK bit pulses next cycle; not recorded in ARRIVED,
//   does not affect FSM. Prevents non-participants from hanging.
//  CORE_MASK==0: all requests take the bypass path; FSM stays IDLE.
//  Mask shrink during GATHER: completion re-evaluated every cycle against current MASK; dropped core's
//   ARRIVED bit cleared; if remaining participants complete -> RELEASE next cycle.
//  Mask grow during GATHER: new core becomes required; barrier waits for it.
//  Duplicate SYNC_EN from a core whose ARRIVED bit is set: ignored, ERR_DUP sets.
//  Timer: counts only in GATHER, saturates at TIMEOUT_CYCLES; reaching it sets TIMEOUT; barrier keeps waiting.
//  CLR and a new error event in the same cycle: the event wins (flag stays 1).
//  BUSY = (FSM==GATHER). GEN wraps 2^GEN_W-1 -> 0.
//  RST mid-GATHER: all arrivals discarded, no SYNC_ACK emitted; cores must re-issue sync.
// TESTING
//  1. MASK=4'b1111, SYNC_EN pulses core0@t1, core2@t3, core1@t4, core3@t6 -> SYNC_ACK=4'b1111 at t7 only, GEN=1.
//  2. MASK=4'b0011, all four cores pulse SYNC_EN same cycle t0 -> SYNC_ACK=4'b1111 at t1 (cores 2,3 by bypass), GEN=1.
//  3. MASK=4'b1111, cores 0,1,2 arrive; MASK->4'b0111 at t10 -> SYNC_ACK=4'b0111 at t11, ARRIVED=0.
//  4. Core0 pulses twice in GATHER -> ERR_DUP=1, held until CLR; barrier still completes normally.
//  5. TIMEOUT_CYCLES=8, only core0 arrives -> TIMEOUT=1 after 8 GATHER cycles; core1..3 then arrive -> ack, TIMEOUT stays 1.
//  6. Core1 pulses in RELEASE cycle; RST mid-GATHER later -> ARRIVED=0, no ack; GEN wraps 255->0 after 256 barriers.

Source files
------------

// File: rtl/mtsp_sync_barrier.sv
// Multi-core sync barrier responder: gathers sync requests from participating cores and
// releases all of them with a one-cycle ack once the last participant has arrived.
//
// state   | meaning
// IDLE    | no arrivals pending
// GATHER  | at least one participant arrived, waiting for the rest
// RELEASE | single cycle in which SYNC_ACK is presented to the participants
module mtsp_sync_barrier #(
  parameter int CORE_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GEN_W          = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CORE_COUNT-1:0] CORE_MASK,
  input  logic [CORE_COUNT-1:0] SYNC_EN,
  output logic [CORE_COUNT-1:0] SYNC_ACK,
  output logic [CORE_COUNT-1:0] ARRIVED,
  output logic                  BUSY,
  output logic [GEN_W-1:0]      GEN,
  output logic                  TIMEOUT,
  output logic                  ERR_DUP,
  input  logic                  CLR
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GATHER  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam bit              TMO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int              TMR_W   = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [TMR_W-1:0]      timer;
  logic [CORE_COUNT-1:0] req_part;
  logic [CORE_COUNT-1:0] req_bypass;
  logic [CORE_COUNT-1:0] arrived_nxt;
  logic                  complete;
  logic                  dup_evt;
  logic                  tmo_evt;

  assign req_part    = SYNC_EN & CORE_MASK;
  assign req_bypass  = SYNC_EN & ~CORE_MASK;
  // Dropping a core from the mask also drops its arrival, so completion tracks the live mask.
  assign arrived_nxt = (ARRIVED | req_part) & CORE_MASK;
  assign complete    = (|CORE_MASK) && (arrived_nxt == CORE_MASK);
  assign dup_evt     = |(req_part & ARRIVED);
  assign tmo_evt     = TMO_EN && (state == GATHER) && (timer == TMR_MAX - 1'b1);
  assign BUSY        = (state == GATHER);

  // Next state depends only on the arrival set, so a RELEASE cycle can chain straight into another.
  always_comb begin
    state_nxt = IDLE;
    if (complete) begin
      state_nxt = RELEASE;
    end else if (|arrived_nxt) begin
      state_nxt = GATHER;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      timer    <= '0;
      SYNC_ACK <= '0;
      ARRIVED  <= '0;
      GEN      <= '0;
      TIMEOUT  <= 1'b0;
      ERR_DUP  <= 1'b0;
    end else begin
      state    <= state_nxt;
      SYNC_ACK <= req_bypass | (complete ? CORE_MASK : '0);
      ARRIVED  <= complete ? '0 : arrived_nxt;
      if (complete) begin
        GEN <= GEN + 1'b1;
      end
      if (state_nxt != GATHER) begin
        timer <= '0;
      end else if (TMO_EN && (state == GATHER) && (timer != TMR_MAX)) begin
        timer <= timer + 1'b1;
      end
      // A new error event outranks a simultaneous clear.
      TIMEOUT <= (TIMEOUT & ~CLR) | tmo_evt;
      ERR_DUP <= (ERR_DUP & ~CLR) | dup_evt;
    end
  end

endmodule

// File: tb/tb_mtsp_sync_barrier.sv
// Directed bench for mtsp_sync_barrier: expected acks are queued as stimulus is driven and
// checked one cycle later; status outputs are checked against bench-side expectations.
module tb_mtsp_sync_barrier;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] CORE_MASK = '0;
  logic [3:0] SYNC_EN = '0;
  logic       CLR = 1'b0;
  logic [3:0] SYNC_ACK;
  logic [3:0] ARRIVED;
  logic       BUSY;
  logic [7:0] GEN;
  logic       TIMEOUT;
  logic       ERR_DUP;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [3:0] ack_q[$];
  logic [7:0] exp_gen = '0;

  always #5 CLK = ~CLK;

  mtsp_sync_barrier #(
    .CORE_COUNT    (4),
    .TIMEOUT_CYCLES(8),
    .GEN_W         (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CORE_MASK(CORE_MASK),
    .SYNC_EN  (SYNC_EN),
    .SYNC_ACK (SYNC_ACK),
    .ARRIVED  (ARRIVED),
    .BUSY     (BUSY),
    .GEN      (GEN),
    .TIMEOUT  (TIMEOUT),
    .ERR_DUP  (ERR_DUP),
    .CLR      (CLR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the ack expected in the following cycle is queued then checked.
  task automatic step(input logic [3:0] m, input logic [3:0] en, input logic clr,
                      input logic [3:0] exp_ack);
    logic [3:0] e;
    CORE_MASK = m;
    SYNC_EN   = en;
    CLR       = clr;
    ack_q.push_back(exp_ack);
    @(posedge CLK);
    #1;
    SYNC_EN = '0;
    CLR     = 1'b0;
    e = ack_q.pop_front();
    chk("sync_ack", {28'd0, SYNC_ACK}, {28'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ack", {28'd0, SYNC_ACK}, 32'h0);
    chk("rst_arrived", {28'd0, ARRIVED}, 32'h0);
    chk("rst_busy", {31'd0, BUSY}, 32'h0);
    chk("rst_gen", {24'd0, GEN}, 32'h0);
    chk("rst_timeout", {31'd0, TIMEOUT}, 32'h0);
    chk("rst_err_dup", {31'd0, ERR_DUP}, 32'h0);
    RST = 1'b0;

    // Staggered arrivals of all four cores
    step(4'hF, 4'h0, 0, 4'h0);
    step(4'hF, 4'h1, 0, 4'h0);
    chk("t1_arrived", {28'd0, ARRIVED}, 32'h1);
    chk("t1_busy", {31'd0, BUSY}, 32'h1);
    step(4'hF, 4'h0, 0, 4'h0);
    step(4'hF, 4'h4, 0, 4'h0);
    step(4'hF, 4'h2, 0, 4'h0);
    step(4'hF, 4'h0, 0, 4'h0);
    step(4'hF, 4'h8, 0, 4'hF);
    exp_gen++;
    chk("t1_gen", {24'd0, GEN}, {24'd0, exp_gen});
    chk("t1_arrived_clr", {28'd0, ARRIVED}, 32'h0);
    chk("t1_busy_rel", {31'd0, BUSY}, 32'h0);
    step(4'hF, 4'h0, 0, 4'h0);

    // Partial mask with bypassed non-participants in the same cycle
    step(4'h3, 4'hF, 0, 4'hF);
    exp_gen++;
    chk("t2_gen", {24'd0, GEN}, {24'd0, exp_gen});
    step(4'h3, 4'h0, 0, 4'h0);

    // Empty mask: everything bypasses, FSM stays idle
    step(4'h0, 4'hF, 0, 4'hF);
    chk("mask0_busy", {31'd0, BUSY}, 32'h0);
    chk("mask0_gen", {24'd0, GEN}, {24'd0, exp_gen});
    step(4'h0, 4'h0, 0, 4'h0);

    // Mask shrink completes the barrier
    step(4'hF, 4'h1, 0, 4'h0);
    step(4'hF, 4'h2, 0, 4'h0);
    step(4'hF, 4'h4, 0, 4'h0);
    chk("t3_arrived", {28'd0, ARRIVED}, 32'h7);
    step(4'hF, 4'h0, 0, 4'h0);
    step(4'hF, 4'h0, 0, 4'h0);
    step(4'h7, 4'h0, 0, 4'h7);
    exp_gen++;
    chk("t3_arrived_clr", {28'd0, ARRIVED}, 32'h0);
    chk("t3_gen", {24'd0, GEN}, {24'd0, exp_gen});
    step(4'hF, 4'h0, 0, 4'h0);

    // Duplicate request sets ERR_DUP, barrier still completes
    step(4'hF, 4'h1, 0, 4'h0);
    step(4'hF, 4'h1, 0, 4'h0);
    chk("t4_err_dup", {31'd0, ERR_DUP}, 32'h1);
    chk("t4_arrived", {28'd0, ARRIVED}, 32'h1);
    step(4'hF, 4'h2, 0, 4'h0);
    step(4'hF, 4'h0, 0, 4'h0);
    step(4'hF, 4'hC, 0, 4'hF);
    exp_gen++;
    chk("t4_gen", {24'd0, GEN}, {24'd0, exp_gen});
    chk("t4_err_held", {31'd0, ERR_DUP}, 32'h1);
    step(4'hF, 4'h0, 1, 4'h0);
    chk("t4_err_clr", {31'd0, ERR_DUP}, 32'h0);
    // CLR coincident with a new duplicate: the event wins
    step(4'hF, 4'h1, 0, 4'h0);
    step(4'hF, 4'h1, 1, 4'h0);
    chk("t4_clr_vs_evt", {31'd0, ERR_DUP}, 32'h1);
    step(4'hF, 4'hE, 0, 4'hF);
    exp_gen++;
    step(4'hF, 4'h0, 1, 4'h0);
    chk("t4_err_clr2", {31'd0, ERR_DUP}, 32'h0);
    chk("pre_t5_timeout", {31'd0, TIMEOUT}, 32'h0);

    // Timeout after eight gather cycles, barrier keeps waiting
    step(4'hF, 4'h1, 0, 4'h0);
    repeat (7) step(4'hF, 4'h0, 0, 4'h0);
    chk("t5_timeout_early", {31'd0, TIMEOUT}, 32'h0);
    step(4'hF, 4'h0, 0, 4'h0);
    chk("t5_timeout_set", {31'd0, TIMEOUT}, 32'h1);
    chk("t5_busy", {31'd0, BUSY}, 32'h1);
    repeat (3) step(4'hF, 4'h0, 0, 4'h0);
    step(4'hF, 4'hE, 0, 4'hF);
    exp_gen++;
    chk("t5_gen", {24'd0, GEN}, {24'd0, exp_gen});
    chk("t5_timeout_sticky", {31'd0, TIMEOUT}, 32'h1);
    step(4'hF, 4'h0, 1, 4'h0);
    chk("t5_timeout_clr", {31'd0, TIMEOUT}, 32'h0);

    // Mask grow: newly required core must arrive before release
    step(4'h3, 4'h1, 0, 4'h0);
    step(4'h7, 4'h2, 0, 4'h0);
    chk("grow_busy", {31'd0, BUSY}, 32'h1);
    step(4'h7, 4'h4, 0, 4'h7);
    exp_gen++;
    chk("grow_gen", {24'd0, GEN}, {24'd0, exp_gen});

    // Arrival in RELEASE that alone completes the mask chains into another release
    step(4'h1, 4'h1, 0, 4'h1);
    step(4'h1, 4'h1, 0, 4'h1);
    exp_gen += 2;
    chk("chain_gen", {24'd0, GEN}, {24'd0, exp_gen});
    step(4'h1, 4'h0, 0, 4'h0);

    // Arrival during RELEASE is kept; reset mid-gather discards it
    step(4'hF, 4'hF, 0, 4'hF);
    exp_gen++;
    chk("t6_gen", {24'd0, GEN}, {24'd0, exp_gen});
    step(4'hF, 4'h2, 0, 4'h0);
    chk("t6_rel_arrived", {28'd0, ARRIVED}, 32'h2);
    chk("t6_rel_busy", {31'd0, BUSY}, 32'h1);
    step(4'hF, 4'h1, 0, 4'h0);
    chk("t6_arrived2", {28'd0, ARRIVED}, 32'h3);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("t6_rst_ack", {28'd0, SYNC_ACK}, 32'h0);
    chk("t6_rst_arrived", {28'd0, ARRIVED}, 32'h0);
    chk("t6_rst_busy", {31'd0, BUSY}, 32'h0);
    chk("t6_rst_gen", {24'd0, GEN}, 32'h0);
    exp_gen = '0;
    step(4'hF, 4'h0, 0, 4'h0);
    step(4'hF, 4'h4, 0, 4'h0);
    chk("t6_rearm_arrived", {28'd0, ARRIVED}, 32'h4);
    step(4'hF, 4'hB, 0, 4'hF);
    exp_gen++;

    // Generation counter wrap
    for (int i = 0; i < 254; i++) begin
      step(4'h1, 4'h1, 0, 4'h1);
      exp_gen++;
    end
    chk("gen_255", {24'd0, GEN}, {24'd0, exp_gen});
    step(4'h1, 4'h1, 0, 4'h1);
    exp_gen++;
    chk("gen_wrap", {24'd0, GEN}, {24'd0, exp_gen});
    step(4'h1, 4'h0, 0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
